// File: rtl/sha_256_block_ctrl.sv
// ---------------------------------------------------------------------------
// sha_256_block_ctrl
//
// Sequenced SHA-256 compression controller. Takes pre-padded 512-bit blocks
// and runs one compression round per clock over a rolling 16-word message
// schedule. The H0..H7 chaining state carries across the blocks of a message.
// After the last block, the 256-bit digest is presented until acknowledged.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   i_block     padded block, W0 = i_block[511:480] ... W15 = i_block[31:0]
//   i_valid     block valid
//   i_first     block starts a message (H reloaded with IV)
//   i_last      block ends a message (digest produced after it)
//   o_ready     controller can accept a block (IDLE only)
//   o_digest    {H0..H7}, H0 in [255:224]; reads 0 outside DONE
//   o_valid     digest valid (DONE)
//   i_ack       consumer takes the digest
//   o_busy      high while rounds or the final add are in progress
//
// Handshake: a block transfers on a rising edge where i_valid & o_ready are
// both high. i_first, i_last and i_block are sampled only on that edge. The
// digest transfers on a rising edge where o_valid & i_ack are both high.
// i_valid is ignored while o_ready is low, and i_ack is ignored while o_valid
// is low.
//
// Debug: state_q (state_e) is the FSM state register. r_q is the round index.
// ---------------------------------------------------------------------------
module sha_256_block_ctrl #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] i_block,
  input  logic         i_valid,
  input  logic         i_first,
  input  logic         i_last,
  output logic         o_ready,
  output logic [255:0] o_digest,
  output logic         o_valid,
  input  logic         i_ack,
  output logic         o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  r_q, r_d;
  logic        last_q, last_d;
  logic [31:0] h_q [8];   // chaining state H0..H7
  logic [31:0] h_d [8];
  logic [31:0] v_q [8];   // working registers a..h
  logic [31:0] v_d [8];
  logic [31:0] w_q [16];  // schedule window; w_q[0] is W[r]
  logic [31:0] w_d [16];

  logic [31:0] t1, t2, w_new, ch, maj;
  logic        accept;

  // Round datapath. The window shifts on every round, so w_q[0] is always
  // W[r]; for r<16 that is simply the latched block word. w_new is W[r+16]
  // = s1(W[r+14]) + W[r+9] + s0(W[r+1]) + W[r].
  always_comb begin
    ch    = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
    maj   = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
    t1    = v_q[7] + bsig1(v_q[4]) + ch + K_ROM[r_q[5:0]] + w_q[0];
    t2    = bsig0(v_q[0]) + maj;
    w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
  end

  assign accept = (state_q == S_IDLE) && i_valid;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    last_d  = last_q;
    h_d     = h_q;
    v_d     = v_q;
    w_d     = w_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          for (int i = 0; i < 16; i++) begin
            w_d[i] = i_block[511 - 32*i -: 32];
          end
          last_d = i_last;
          if (i_first) begin
            h_d = IV;
            v_d = IV;
          end else begin
            v_d = h_q;
          end
          r_d     = '0;
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        v_d[0] = t1 + t2;
        v_d[1] = v_q[0];
        v_d[2] = v_q[1];
        v_d[3] = v_q[2];
        v_d[4] = v_q[3] + t1;
        v_d[5] = v_q[4];
        v_d[6] = v_q[5];
        v_d[7] = v_q[6];
        for (int i = 0; i < 15; i++) begin
          w_d[i] = w_q[i+1];
        end
        w_d[15] = w_new;
        if (r_q == LAST_ROUND) begin
          state_d = S_FINAL;
        end else begin
          r_d = r_q + 7'd1;
        end
      end

      S_FINAL: begin
        for (int i = 0; i < 8; i++) begin
          h_d[i] = h_q[i] + v_q[i];
        end
        r_d     = '0;
        state_d = last_q ? S_DONE : S_IDLE;
      end

      S_DONE: begin
        // H keeps the digest after ack so a first=0 block can continue it.
        if (i_ack) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= IV[i];
        v_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      last_q  <= last_d;
      h_q     <= h_d;
      v_q     <= v_d;
      w_q     <= w_d;
    end
  end

  // Outputs are forced low while rst is high, so nothing leaks during reset.
  assign o_ready  = (state_q == S_IDLE) && !rst;
  assign o_valid  = (state_q == S_DONE) && !rst;
  assign o_busy   = ((state_q == S_ROUND) || (state_q == S_FINAL)) && !rst;
  assign o_digest = o_valid ? {h_q[0], h_q[1], h_q[2], h_q[3],
                               h_q[4], h_q[5], h_q[6], h_q[7]} : '0;

endmodule

// File: tb/tb_sha_256_block_ctrl.sv
module tb_sha_256_block_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] i_block;
  logic         i_valid;
  logic         i_first;
  logic         i_last;
  logic         o_ready;
  logic [255:0] o_digest;
  logic         o_valid;
  logic         i_ack;
  logic         o_busy;

  int total = 0;
  int bad   = 0;
  logic [255:0] exp_q[$];

  sha_256_block_ctrl #(.ROUNDS(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_block  (i_block),
    .i_valid  (i_valid),
    .i_first  (i_first),
    .i_last   (i_last),
    .o_ready  (o_ready),
    .o_digest (o_digest),
    .o_valid  (o_valid),
    .i_ack    (i_ack),
    .o_busy   (o_busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model (FIPS 180-4 compression) ----------------
  localparam logic [255:0] IV_H =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) hv[i] = hin[255 - 32*i -: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
    e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int r = 0; r < 64; r++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K_TB[r] + w[r];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    res = {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
           hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
    return res;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] blk;
    for (int k = 0; k < 16; k++) blk[32*k +: 32] = $urandom();
    return blk;
  endfunction

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the handshake edge.
  task automatic send(input logic [511:0] blk, input logic first, input logic last);
    int n = 0;
    i_block = blk; i_first = first; i_last = last; i_valid = 1'b1;
    while (!o_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 256'(n < 300), 256'(1));
    @(negedge clk);
    i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
  endtask

  // Observes the cycles after a handshake: cycle j=1 is the first round,
  // j=65 the final add, j=66 DONE (last) or IDLE (not last).
  task automatic run_block(input logic last);
    int early = 0;
    check("busy_round", 256'(o_busy), 256'(1));
    check("ready_round", 256'(o_ready), 256'(0));
    for (int j = 2; j <= 66; j++) begin
      @(negedge clk);
      if (j == 65) check("busy_final", 256'(o_busy), 256'(1));
      if (j < 66 && o_valid) early++;
    end
    check("valid_early", 256'(early), 256'(0));
    check("busy_after", 256'(o_busy), 256'(0));
    check("valid_at_66", 256'(o_valid), 256'(last));
    check("ready_at_66", 256'(o_ready), 256'(!last));
  endtask

  task automatic check_digest(input string tag);
    logic [255:0] e;
    e = exp_q.pop_front();
    check(tag, o_digest, e);
  endtask

  task automatic do_ack();
    i_ack = 1'b1;
    @(negedge clk);
    i_ack = 1'b0;
    check("ack_valid", 256'(o_valid), 256'(0));
    check("ack_digest", o_digest, 256'(0));
    check("ack_ready", 256'(o_ready), 256'(1));
  endtask

  // ---------------- stimulus ----------------
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  initial begin
    logic [511:0] blk_abc, blk_empty, blk_two1, blk_two2, blk;
    logic [255:0] h_model, d_prev;
    int accepts[$];
    int nb, n;

    blk_abc   = {32'h61626380, 448'h0, 32'h00000018};
    blk_empty = {32'h80000000, 480'h0};
    blk_two1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blk_two2  = {480'h0, 32'h000001c0};

    rst = 1'b1; i_block = '0; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0; i_ack = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 256'(o_ready), 256'(0));
    check("rst_valid", 256'(o_valid), 256'(0));
    check("rst_digest", o_digest, 256'(0));
    check("rst_busy", 256'(o_busy), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 256'(o_ready), 256'(1));

    // "abc"
    exp_q.push_back(D_ABC);
    send(blk_abc, 1'b1, 1'b1);
    run_block(1'b1);
    check_digest("abc_digest");
    do_ack();

    // empty message
    exp_q.push_back(D_EMPTY);
    send(blk_empty, 1'b1, 1'b1);
    run_block(1'b1);
    check_digest("empty_digest");
    do_ack();

    // two-block 56-byte message
    send(blk_two1, 1'b1, 1'b0);
    run_block(1'b0);
    exp_q.push_back(D_TWO);
    send(blk_two2, 1'b0, 1'b1);
    run_block(1'b1);
    check_digest("two_block_digest");
    do_ack();

    // backpressure: hold the digest 20 cycles while i_valid pulses
    exp_q.push_back(D_ABC);
    send(blk_abc, 1'b1, 1'b1);
    run_block(1'b1);
    check_digest("bp_digest");
    for (int k = 0; k < 20; k++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_block = rand_block();
      i_first = 1'b1;
      @(negedge clk);
      check("bp_hold_valid", 256'(o_valid), 256'(1));
      check("bp_hold_digest", o_digest, D_ABC);
      check("bp_hold_ready", 256'(o_ready), 256'(0));
    end
    i_valid = 1'b0; i_first = 1'b0;
    do_ack();
    exp_q.push_back(D_ABC);
    send(blk_abc, 1'b1, 1'b1);
    run_block(1'b1);
    check_digest("abc_after_bp");
    do_ack();

    // reset at round 30
    send(blk_abc, 1'b1, 1'b1);
    for (int j = 2; j <= 31; j++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 256'(o_busy), 256'(0));
    check("midrst_valid", 256'(o_valid), 256'(0));
    check("midrst_ready", 256'(o_ready), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 256'(o_ready), 256'(1));
    check("midrst_busy_after", 256'(o_busy), 256'(0));
    exp_q.push_back(D_ABC);
    send(blk_abc, 1'b1, 1'b1);
    run_block(1'b1);
    check_digest("abc_after_rst");
    do_ack();

    // i_valid held: one accept every 66 cycles
    i_valid = 1'b1; i_first = 1'b1; i_last = 1'b0; i_block = rand_block();
    for (int c = 0; c < 140; c++) begin
      if (o_ready) accepts.push_back(c);
      @(negedge clk);
    end
    i_valid = 1'b0; i_first = 1'b0;
    check("held_accept_count", 256'(accepts.size()), 256'(3));
    for (int k = 1; k < accepts.size(); k++) begin
      check("held_accept_gap", 256'(accepts[k] - accepts[k-1]), 256'(66));
    end
    n = 0;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("held_drain", 256'(o_ready), 256'(1));

    // random multi-block messages against the model
    for (int m = 0; m < 4; m++) begin
      nb = $urandom_range(1, 3);
      h_model = IV_H;
      for (int b = 0; b < nb; b++) begin
        blk = rand_block();
        h_model = compress(h_model, blk);
        if (b == nb - 1) exp_q.push_back(h_model);
        send(blk, 1'(b == 0), 1'(b == nb - 1));
        run_block(1'(b == nb - 1));
      end
      check_digest("rand_msg_digest");
      d_prev = h_model;
      do_ack();
      // first=0 after a digest continues from that digest
      blk = rand_block();
      exp_q.push_back(compress(d_prev, blk));
      send(blk, 1'b0, 1'b1);
      run_block(1'b1);
      check_digest("continue_digest");
      do_ack();
    end

    // first=1 after a completed message restarts from IV
    exp_q.push_back(D_ABC);
    send(blk_abc, 1'b1, 1'b1);
    run_block(1'b1);
    check_digest("restart_from_iv");
    do_ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
